// File: rtl/button_to_led_ctrl.sv
// Debounced two-key push-button front end driving ten status LEDs.
// Keys are synchronised, debounced per key, then mapped to levels, toggles and a press count.
module button_to_led_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] KEY,
   output logic [9:0] LEDR
);

   localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]            s1_q, s2_q;
   logic [1:0]            db_q, db_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            press_q, press_d;
   logic [3:0]            lvl_q, lvl_d;
   logic [1:0]            tog_q, tog_d;
   logic [3:0]            pcnt_q, pcnt_d;
   logic [1:0]            pr_c;

   // Per-key stability counter; a press is flagged on the cycle a low level is accepted.
   always_comb begin
      db_d    = db_q;
      cnt_d   = '0;
      press_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i]    = s2_q[i];
               press_d[i] = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // LED sources; press_q lines up with the first cycle db_q reads pressed.
   always_comb begin
      pr_c   = ~db_q;
      lvl_d  = {pr_c[0] ^ pr_c[1], pr_c[0] & pr_c[1], pr_c[1], pr_c[0]};
      tog_d  = tog_q ^ press_q;
      pcnt_d = pcnt_q + 4'(press_q[0]);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         s1_q    <= 2'b11;
         s2_q    <= 2'b11;
         db_q    <= 2'b11;
         cnt_q   <= '0;
         press_q <= '0;
         lvl_q   <= '0;
         tog_q   <= '0;
         pcnt_q  <= '0;
      end else begin
         s1_q    <= KEY;
         s2_q    <= s1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         lvl_q   <= lvl_d;
         tog_q   <= tog_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign LEDR = {pcnt_q, tog_q, lvl_q};

endmodule

// File: tb/tb_button_to_led_ctrl.sv
// Directed bench for button_to_led_ctrl with a 4-cycle debounce window.
module tb_button_to_led_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key = 2'b11;
   logic [9:0] ledr;
   int         checks = 0;
   int         errors = 0;

   button_to_led_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .KEY      (key),
      .LEDR     (ledr)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [9:0] exp);
      checks++;
      assert (ledr === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, ledr, exp);
      end
   endtask

   // Press one key from idle, check the held value on the 7th edge, then release.
   task automatic press_key(input int idx, input logic [9:0] exp_held,
                            input logic [9:0] exp_rel, input string tag);
      logic [1:0] k;
      k = 2'b11;
      k[idx] = 1'b0;
      key = k;
      tick(7);
      chk({tag, "_held"}, exp_held);
      tick(1);
      key = 2'b11;
      tick(8);
      chk({tag, "_rel"}, exp_rel);
   endtask

   logic [9:0] e;

   initial begin
      // Reset with keys released
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("reset_hold", 10'b0);
      end
      rst_n = 1'b1;
      tick(10);
      chk("after_reset_11", 10'b0);

      // Level map across key states, with exact latency
      key = 2'b10;
      tick(6);
      chk("k10_early", 10'b0000000000);
      tick(1);
      chk("k10_edge6", 10'b0001011001);
      tick(3);
      chk("k10_hold", 10'b0001011001);

      key = 2'b01;
      tick(6);
      chk("k01_early", 10'b0001011001);
      tick(1);
      chk("k01_edge6", 10'b0001111010);
      tick(3);

      key = 2'b00;
      tick(6);
      chk("k00_early", 10'b0001111010);
      tick(1);
      chk("k00_edge6", 10'b0010100111);
      tick(3);

      key = 2'b11;
      tick(10);
      chk("k11_idle", 10'b0010100000);

      // Three-sample glitch must leave every bit untouched
      key = 2'b10;
      tick(1);
      chk("glitch3", 10'b0010100000);
      tick(1);
      chk("glitch3", 10'b0010100000);
      tick(1);
      chk("glitch3", 10'b0010100000);
      key = 2'b11;
      for (int t = 0; t < 12; t++) begin
         tick(1);
         chk("glitch3", 10'b0010100000);
      end

      // Exactly four samples low is accepted as a press
      key = 2'b10;
      tick(4);
      chk("glitch4_pre", 10'b0010100000);
      key = 2'b11;
      for (int t = 1; t <= 10; t++) begin
         tick(1);
         if (t <= 2)      e = 10'b0010100000;
         else if (t <= 6) e = 10'b0011111001;
         else             e = 10'b0011110000;
         chk("glitch4", e);
      end

      // Clear state before the wrap sequence
      rst_n = 1'b0;
      tick(1);
      chk("reset_clear", 10'b0);
      rst_n = 1'b1;
      tick(4);

      // Sixteen key-0 presses wrap the counter and return toggle 0 to zero
      for (int n = 1; n <= 16; n++) begin
         e = {4'(n % 16), 1'b0, 1'(n % 2), 4'b0000};
         press_key(0, e | 10'b0000001001, e, "wrap");
      end
      chk("wrap_end", 10'b0000000000);

      // Key-1 presses toggle LEDR[5] and leave the counter alone
      for (int n = 1; n <= 3; n++) begin
         e = {4'b0000, 1'(n % 2), 1'b0, 4'b0000};
         press_key(1, e | 10'b0000001010, e, "key1");
      end

      // Both keys pressed together
      key = 2'b00;
      tick(6);
      chk("simul_early", 10'b0000100000);
      tick(1);
      chk("simul_edge6", 10'b0001010111);
      key = 2'b11;
      tick(8);
      chk("simul_rel", 10'b0001010000);

      // Reset mid-debounce with key held through reset
      key = 2'b10;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      chk("midop_reset", 10'b0);
      tick(2);
      chk("midop_reset_hold", 10'b0);
      rst_n = 1'b1;
      tick(6);
      chk("held_early", 10'b0);
      tick(1);
      chk("held_press", 10'b0001011001);
      key = 2'b11;
      tick(8);
      chk("held_rel", 10'b0001010000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
